// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter that shares one device port among NrHosts request/response hosts.
// Only one transaction can be outstanding at a time. A missing response is ended by a timeout that reports an error.
module bus_host_arbiter #(
  parameter int NrHosts       = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                                clk_sys_i,
  input  logic                                rst_sys_ni,
  input  logic [NrHosts-1:0]                  host_req_i,
  output logic [NrHosts-1:0]                  host_gnt_o,
  input  logic [NrHosts-1:0][AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                  host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0] host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]                  host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]   host_rdata_o,
  output logic [NrHosts-1:0]                  host_err_o,
  output logic                                dev_req_o,
  output logic                                dev_we_o,
  output logic [AddrWidth-1:0]                dev_addr_o,
  output logic [DataWidth/8-1:0]              dev_be_o,
  output logic [DataWidth-1:0]                dev_wdata_o,
  input  logic                                dev_gnt_i,
  input  logic                                dev_rvalid_i,
  input  logic                                dev_err_i,
  input  logic [DataWidth-1:0]                dev_rdata_i
);

  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam logic [15:0]     TimeoutLast = 16'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] LastInit    = IdxW'(NrHosts - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IdxW-1:0] sel_idx, cand, cur_idx;
  logic            sel_found;
  logic            timeout;
  logic            rdata_zero;

  // Search starts just after the last granted host, so every requester is served in turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NrHosts; k++) begin
      cand = IdxW'((int'(last_q) + k) % NrHosts);
      if (!sel_found && host_req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign cur_idx     = (state_q == ST_IDLE) ? sel_idx : owner_q;
  assign dev_addr_o  = host_addr_i[cur_idx];
  assign dev_we_o    = host_we_i[cur_idx];
  assign dev_be_o    = host_be_i[cur_idx];
  assign dev_wdata_o = host_wdata_i[cur_idx];
  assign timeout     = (cnt_q == TimeoutLast);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LastInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cnt_d         = '0;
    dev_req_o     = 1'b0;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    rdata_zero    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          dev_req_o           = 1'b1;
          owner_d             = sel_idx;
          host_gnt_o[sel_idx] = dev_gnt_i;
          if (dev_gnt_i) begin
            state_d = ST_RESP;
            last_d  = sel_idx;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // The owner withdrawing its request abandons the transfer without a grant.
        if (!host_req_i[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          dev_req_o           = 1'b1;
          host_gnt_o[owner_q] = dev_gnt_i;
          if (dev_gnt_i) begin
            state_d = ST_RESP;
            last_d  = owner_q;
          end
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (dev_rvalid_i) begin
          host_rvalid_o[owner_q] = 1'b1;
          host_err_o[owner_q]    = dev_err_i;
          state_d                = ST_IDLE;
          cnt_d                  = '0;
        end else if (timeout) begin
          host_rvalid_o[owner_q] = 1'b1;
          host_err_o[owner_q]    = 1'b1;
          rdata_zero             = 1'b1;
          state_d                = ST_IDLE;
          cnt_d                  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NrHosts; i++) begin
      host_rdata_o[i] = rdata_zero ? '0 : dev_rdata_i;
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench for bus_host_arbiter. Stimulus queues the expected device requests and host responses.
// An independent negedge monitor compares the DUT outputs against those queues.
module tb_bus_host_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]         host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [N-1:0][AW-1:0] host_addr;
  logic [N-1:0][BW-1:0] host_be;
  logic [N-1:0][DW-1:0] host_wdata, host_rdata;
  logic          dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
  logic [AW-1:0] dev_addr;
  logic [BW-1:0] dev_be;
  logic [DW-1:0] dev_wdata, dev_rdata;

  bus_host_arbiter #(.NrHosts(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(T)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_addr_o(dev_addr), .dev_be_o(dev_be),
    .dev_wdata_o(dev_wdata), .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
    .dev_err_i(dev_err), .dev_rdata_i(dev_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {int host; logic [AW-1:0] addr; logic we; logic [BW-1:0] be; logic [DW-1:0] wdata;} req_t;
  typedef struct {int host; logic err; logic [DW-1:0] rdata; int cyc;} rsp_t;

  req_t gnt_q[$];
  rsp_t rsp_q[$];
  req_t m_req;
  rsp_t m_rsp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   exp_req  = 1'b0;
  int   last_g   = N - 1;
  logic [N-1:0] oh;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT against the queued expectations, independently of the stimulus.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", 64'({host_gnt, host_rvalid, host_err, dev_req}), 64'd0);
    end else begin
      chk("dev_req", 64'(dev_req), 64'(exp_req));
      if (exp_req && gnt_q.size() == 0) begin
        chk("pending_request", 64'd0, 64'd1);
      end else if (exp_req) begin
        m_req = gnt_q[0];
        chk("dev_addr", 64'(dev_addr), 64'(m_req.addr));
        chk("dev_we", 64'(dev_we), 64'(m_req.we));
        chk("dev_be", 64'(dev_be), 64'(m_req.be));
        chk("dev_wdata", 64'(dev_wdata), 64'(m_req.wdata));
        oh = '0;
        if (dev_gnt) oh[m_req.host] = 1'b1;
        chk("host_gnt", 64'(host_gnt), 64'(oh));
        if (dev_gnt) void'(gnt_q.pop_front());
      end else begin
        chk("host_gnt_zero", 64'(host_gnt), 64'd0);
      end
      if (host_rvalid != '0) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rvalid", 64'(host_rvalid), 64'd0);
        end else begin
          m_rsp = rsp_q.pop_front();
          oh = '0;
          oh[m_rsp.host] = 1'b1;
          chk("rsp_cycle", 64'(cyc), 64'(m_rsp.cyc));
          chk("host_rvalid", 64'(host_rvalid), 64'(oh));
          chk("host_err", 64'(host_err), m_rsp.err ? 64'(oh) : 64'd0);
          for (int i = 0; i < N; i++) chk("host_rdata", 64'(host_rdata[i]), 64'(m_rsp.rdata));
        end
      end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
        m_rsp = rsp_q.pop_front();
        oh = '0;
        oh[m_rsp.host] = 1'b1;
        chk("missing_rvalid", 64'(host_rvalid), 64'(oh));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin: first requester after the last granted host.
  function automatic int winner(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_g + k) % N;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      host_addr[i]  = AW'($urandom);
      host_we[i]    = 1'($urandom_range(0, 1));
      host_be[i]    = BW'($urandom);
      host_wdata[i] = DW'($urandom);
    end
  endtask

  // g cycles without dev_gnt before the grant. The response arrives at RESP index r; r >= T means a timeout and then a stray response.
  task automatic txn(input logic [N-1:0] mask, input int g, input int r, input bit abort,
                     input logic rerr, input logic [DW-1:0] rdata);
    int   w, c;
    req_t e;
    rsp_t s;
    rand_fields();
    host_req = mask;
    w = winner(mask);
    e = '{w, host_addr[w], host_we[w], host_be[w], host_wdata[w]};
    gnt_q.push_back(e);
    exp_req = 1'b1;
    for (int k = 0; k < g; k++) begin
      if (abort && k == g - 1 && k > 0) begin
        host_req   = '0;
        exp_req    = 1'b0;
        dev_gnt    = 1'b1;
        dev_rvalid = 1'b0;
        void'(gnt_q.pop_front());
        tick();
        dev_gnt = 1'b0;
        return;
      end
      if (k > 0) host_req = host_req | N'($urandom);
      dev_gnt    = 1'b0;
      dev_rvalid = 1'($urandom_range(0, 1));
      dev_err    = 1'($urandom_range(0, 1));
      dev_rdata  = DW'($urandom);
      tick();
    end
    dev_gnt    = 1'b1;
    dev_rvalid = 1'b0;
    c = cyc;
    if (r <= T - 1) s = '{w, rerr, rdata, c + 1 + r};
    else            s = '{w, 1'b1, '0, c + T};
    rsp_q.push_back(s);
    last_g = w;
    tick();
    host_req = '0;
    exp_req  = 1'b0;
    for (int k = 0; k <= r; k++) begin
      dev_gnt = 1'($urandom_range(0, 1));
      if (k == r) begin
        dev_rvalid = 1'b1;
        dev_err    = rerr;
        dev_rdata  = rdata;
      end else begin
        dev_rvalid = 1'b0;
        dev_err    = 1'($urandom_range(0, 1));
        dev_rdata  = DW'($urandom);
      end
      tick();
    end
    dev_rvalid = 1'b0;
    dev_gnt    = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    host_req   = '0;
    host_addr  = '0;
    host_we    = '0;
    host_be    = '0;
    host_wdata = '0;
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b0;
    dev_err    = 1'b0;
    dev_rdata  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Two continuous requesters with an immediate grant and a response one cycle later alternate 0,1,0,1.
    repeat (4) txn(3'b011, 0, 1, 1'b0, 1'b0, DW'($urandom));
    // A held owner keeps the bus while other hosts join during the hold.
    txn(3'b010, 3, 0, 1'b0, 1'b0, DW'($urandom));
    txn(3'b011, 0, 0, 1'b0, 1'b0, DW'($urandom));
    // Timeout followed by a late device response.
    txn(3'b001, 0, T + 1, 1'b0, 1'b0, DW'($urandom));
    // Device response on the timeout cycle takes precedence.
    txn(3'b001, 0, T - 1, 1'b0, 1'b1, 32'hDEADBEEF);
    // Owner withdraws its request during the hold.
    txn(3'b100, 3, 0, 1'b1, 1'b0, DW'($urandom));

    for (int n = 0; n < 150; n++) begin
      int g;
      g = $urandom_range(0, 3);
      txn(N'($urandom_range(1, (1 << N) - 1)), g, $urandom_range(0, T + 2),
          (g >= 2) && ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), DW'($urandom));
    end

    // Reset in RESP abandons the transfer, and round-robin restarts at host 0.
    rand_fields();
    host_req = 3'b001;
    gnt_q.push_back('{0, host_addr[0], host_we[0], host_be[0], host_wdata[0]});
    exp_req = 1'b1;
    dev_gnt = 1'b1;
    tick();
    host_req = '0;
    exp_req  = 1'b0;
    dev_gnt  = 1'b0;
    tick();
    rst_n  = 1'b0;
    last_g = N - 1;
    tick();
    tick();
    rst_n      = 1'b1;
    dev_rvalid = 1'b1;
    dev_rdata  = DW'($urandom);
    tick();
    dev_rvalid = 1'b0;
    tick();
    txn(3'b011, 0, 1, 1'b0, 1'b0, DW'($urandom));

    repeat (3) tick();
    chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
